// File: rtl/rec_f32_to_int_iter_if.sv
// Request/response channels of the recoded-float to integer converter.
// The master drives requests and accepts results; the slave is the converter.
interface rec_f32_to_int_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [32:0] in_bits_in;
    logic [2:0]  in_bits_rounding_mode;
    logic        in_bits_signed_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_bits_out;
    logic [2:0]  out_bits_exception_flags;

    modport master (
        output in_valid, in_bits_in, in_bits_rounding_mode, in_bits_signed_out, out_ready,
        input  in_ready, out_valid, out_bits_out, out_bits_exception_flags
    );

    modport slave (
        input  in_valid, in_bits_in, in_bits_rounding_mode, in_bits_signed_out, out_ready,
        output in_ready, out_valid, out_bits_out, out_bits_exception_flags
    );
endinterface

// File: rtl/rec_f32_to_int_iter.sv
// Iterative recoded-f32 to int32/uint32 converter: the significand is aligned
// 4 bits per cycle, then rounded and range-checked in a single ROUND cycle.
module rec_f32_to_int_iter (
    input  logic                 clock,
    input  logic                 reset,
    rec_f32_to_int_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    state_t      state;
    logic [55:0] acc;
    logic [4:0]  cnt;
    logic        sign_q;
    logic        signed_q;
    logic        nan_q;
    logic        inf_q;
    logic        big_q;
    logic [2:0]  rm_q;
    logic        out_valid_q;
    logic [31:0] out_q;
    logic [2:0]  flags_q;

    logic [8:0]        exp_in;
    logic [22:0]       fract_in;
    logic signed [9:0] e_in;
    logic              is_nan;
    logic              is_inf;
    logic              is_finite;
    logic              is_big;
    logic [55:0]       load_acc;
    logic [4:0]        load_cnt;
    logic [2:0]        sh;

    assign exp_in    = bus.in_bits_in[31:23];
    assign fract_in  = bus.in_bits_in[22:0];
    assign e_in      = $signed({1'b0, exp_in}) - 10'sd256;
    assign is_nan    = (exp_in[8:6] == 3'b111);
    assign is_inf    = (exp_in[8:6] == 3'b110);
    assign is_finite = (exp_in[8:6] != 3'b000) && !is_nan && !is_inf;
    assign is_big    = is_finite && (e_in > 10'sd31);

    // Integer part sits in acc[55:24]; values below 0.5 collapse to a lone sticky bit.
    always_comb begin
        load_acc = '0;
        load_cnt = '0;
        if (is_finite) begin
            if (e_in >= 10'sd0 && e_in <= 10'sd31) begin
                load_acc = {31'd0, 1'b1, fract_in, 1'b0};
                load_cnt = e_in[4:0];
            end else if (e_in == -10'sd1) begin
                load_acc = {32'd0, 1'b1, fract_in};
            end else if (e_in < -10'sd1) begin
                load_acc = 56'd1;
            end
        end
    end

    assign sh = (cnt > 5'd4) ? 3'd4 : cnt[2:0];

    logic [31:0] int_part;
    logic        rb;
    logic        st;
    logic        inexact;
    logic        incr;
    logic [32:0] mag;
    logic        ovf;
    logic        invalid;
    logic [31:0] result;

    always_comb begin
        int_part = acc[55:24];
        rb       = acc[23];
        st       = |acc[22:0];
        inexact  = rb | st;
        incr     = 1'b0;
        case (rm_q)
            3'd0:    incr = rb & (st | int_part[0]);
            3'd2:    incr = sign_q & inexact;
            3'd3:    incr = ~sign_q & inexact;
            3'd4:    incr = rb;
            default: incr = 1'b0;
        endcase
        // Round-to-odd jams the inexact bit into the LSB instead of incrementing.
        if (rm_q == 3'd6)
            mag = {1'b0, int_part[31:1], int_part[0] | inexact};
        else
            mag = {1'b0, int_part} + {32'd0, incr};
        if (signed_q)
            ovf = sign_q ? (mag > 33'h0_8000_0000) : (mag[32] | mag[31]);
        else
            ovf = mag[32] | (sign_q & (mag != 33'd0));
        ovf     = ovf | big_q;
        invalid = nan_q | inf_q | ovf;
        if (invalid)
            result = (nan_q | ~sign_q) ? (signed_q ? 32'h7FFF_FFFF : 32'hFFFF_FFFF)
                                       : (signed_q ? 32'h8000_0000 : 32'h0000_0000);
        else
            result = sign_q ? (32'd0 - mag[31:0]) : mag[31:0];
    end

    // NOTE: every register here, datapath included, updates with non-blocking
    // assignments and is cleared by reset so an aborted operation leaves no residue.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            signed_q    <= 1'b0;
            nan_q       <= 1'b0;
            inf_q       <= 1'b0;
            big_q       <= 1'b0;
            rm_q        <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            flags_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_q   <= bus.in_bits_in[32];
                        rm_q     <= bus.in_bits_rounding_mode;
                        signed_q <= bus.in_bits_signed_out;
                        nan_q    <= is_nan;
                        inf_q    <= is_inf;
                        big_q    <= is_big;
                        acc      <= load_acc;
                        cnt      <= load_cnt;
                        state    <= (load_cnt != 5'd0) ? SHIFT : ROUND;
                    end
                end
                SHIFT: begin
                    acc <= acc << sh;
                    cnt <= cnt - {2'b00, sh};
                    if (cnt <= 5'd4)
                        state <= ROUND;
                end
                ROUND: begin
                    out_q       <= result;
                    flags_q     <= {invalid, 1'b0, inexact & ~invalid};
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready                 = (state == IDLE) & ~reset;
    assign bus.out_valid                = out_valid_q;
    assign bus.out_bits_out             = out_q;
    assign bus.out_bits_exception_flags = flags_q;
endmodule

// File: tb/tb_rec_f32_to_int_iter.sv
// Bench for rec_f32_to_int_iter: directed corner cases plus random requests
// compared against an arithmetic model of float-to-integer rounding.
module tb_rec_f32_to_int_iter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    rec_f32_to_int_iter_if bus ();

    rec_f32_to_int_iter dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EXACT, BELOW, TIE, ABOVE} rem_t;

    typedef struct {
        logic [32:0] x;
        logic [2:0]  rm;
        logic        so;
        logic [31:0] res;
        logic [2:0]  fl;
        int          lat;
    } vec_t;

    // Value = (-1)^s * 1.fract * 2^e; the remainder is classified against one half.
    // Latency counts the accept cycle as cycle 1.
    function automatic void model(input logic [32:0] x, input logic [2:0] rm, input logic so,
                                  output logic [31:0] res, output logic [2:0] fl, output int lat);
        logic [8:0] ex;
        logic       sign;
        logic       up;
        logic       inexact;
        logic       invalid;
        longint     m, ip, rem, half, mag, val;
        int         e, sh;
        rem_t       cls;
        ex   = x[31:23];
        sign = x[32];
        res  = '0;
        fl   = '0;
        lat  = 2;
        val  = 0;
        inexact = 1'b0;
        if (ex[8:6] == 3'b000) return;
        e = int'(ex) - 256;
        if (e >= 1 && e <= 31) lat = 2 + (e + 3) / 4;
        invalid = (ex[8:7] == 2'b11) || (e >= 32);
        if (!invalid) begin
            m  = longint'({1'b1, x[22:0]});
            sh = 23 - e;
            if (sh <= 0) begin
                ip  = m << (-sh);
                cls = EXACT;
            end else if (sh > 40) begin
                ip  = 0;
                cls = BELOW;
            end else begin
                ip   = m >> sh;
                rem  = m - (ip << sh);
                half = longint'(1) << (sh - 1);
                if (rem == 0)         cls = EXACT;
                else if (rem < half)  cls = BELOW;
                else if (rem == half) cls = TIE;
                else                  cls = ABOVE;
            end
            inexact = (cls != EXACT);
            up = 1'b0;
            case (rm)
                3'd0:    up = (cls == ABOVE) || (cls == TIE && ip % 2 == 1);
                3'd2:    up = sign && inexact;
                3'd3:    up = !sign && inexact;
                3'd4:    up = (cls == TIE) || (cls == ABOVE);
                3'd6:    up = inexact && (ip % 2 == 0);
                default: up = 1'b0;
            endcase
            mag = ip + (up ? 1 : 0);
            val = sign ? -mag : mag;
            if (so) invalid = (val < -64'sd2147483648) || (val > 64'sd2147483647);
            else    invalid = (val < 0) || (val > 64'sd4294967295);
        end
        if (invalid) begin
            res = (ex[8:6] == 3'b111 || !sign) ? (so ? 32'h7FFF_FFFF : 32'hFFFF_FFFF)
                                               : (so ? 32'h8000_0000 : 32'h0000_0000);
            fl  = 3'b100;
        end else begin
            res = val[31:0];
            fl  = {2'b00, inexact};
        end
    endfunction

    task automatic send(input logic [32:0] x, input logic [2:0] rm, input logic so);
        int n = 0;
        bus.in_bits_in            = x;
        bus.in_bits_rounding_mode = rm;
        bus.in_bits_signed_out    = so;
        bus.in_valid              = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic ack();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [32:0] x, input logic [2:0] rm, input logic so,
                          output logic [31:0] res, output logic [2:0] fl, output int lat);
        send(x, rm, so);
        wait_valid(lat);
        res = bus.out_bits_out;
        fl  = bus.out_bits_exception_flags;
        ack();
    endtask

    task automatic gen(output logic [32:0] x, output logic [2:0] rm, output logic so);
        logic [8:0]  ex;
        logic [22:0] fract;
        logic [22:0] mask;
        int          sel;
        sel   = $urandom_range(0, 9);
        fract = 23'($urandom);
        if ($urandom_range(0, 1) == 1) begin
            mask  = 23'h7F_FFFF << $urandom_range(0, 23);
            fract = fract & mask;
        end
        case (sel)
            0:       ex = {3'b000, 6'($urandom)};
            1:       ex = {2'b11, 7'($urandom)};
            2:       ex = 9'($urandom_range(64, 253));
            default: ex = 9'(253 + $urandom_range(0, 37));
        endcase
        x  = {1'($urandom), ex, fract};
        rm = 3'($urandom_range(0, 7));
        so = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks += 4;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        if (bus.out_bits_out !== 32'd0) begin n_fail++; $display("FAIL reset_out_bits got %h want 0", bus.out_bits_out); end
        if (bus.out_bits_exception_flags !== 3'd0) begin n_fail++; $display("FAIL reset_flags got %b want 000", bus.out_bits_exception_flags); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_directed();
        vec_t        vt[13];
        logic [31:0] res;
        logic [2:0]  fl;
        int          lat;
        vt[0]  = '{33'h0_8040_0000, 3'd0, 1'b1, 32'd2,         3'b001, 2};
        vt[1]  = '{33'h0_80A0_0000, 3'd0, 1'b1, 32'd2,         3'b001, 3};
        vt[2]  = '{33'h0_80A0_0000, 3'd1, 1'b1, 32'd2,         3'b001, 3};
        vt[3]  = '{33'h0_80A0_0000, 3'd3, 1'b1, 32'd3,         3'b001, 3};
        vt[4]  = '{33'h0_80A0_0000, 3'd4, 1'b1, 32'd3,         3'b001, 3};
        vt[5]  = '{33'h0_80A0_0000, 3'd6, 1'b1, 32'd3,         3'b001, 3};
        vt[6]  = '{33'h1_8F80_0000, 3'd0, 1'b1, 32'h8000_0000, 3'b000, 10};
        vt[7]  = '{33'h1_8F80_0000, 3'd0, 1'b0, 32'h0000_0000, 3'b100, 10};
        vt[8]  = '{33'h0_E000_0000, 3'd0, 1'b1, 32'h7FFF_FFFF, 3'b100, 2};
        vt[9]  = '{33'h0_9000_0000, 3'd0, 1'b0, 32'hFFFF_FFFF, 3'b100, 2};
        vt[10] = '{33'h1_7F00_0000, 3'd0, 1'b0, 32'd0,         3'b001, 2};
        vt[11] = '{33'h1_7FC0_0000, 3'd0, 1'b0, 32'd0,         3'b100, 2};
        vt[12] = '{33'h0_0000_0000, 3'd3, 1'b1, 32'd0,         3'b000, 2};
        for (int i = 0; i < 13; i++) begin
            run_op(vt[i].x, vt[i].rm, vt[i].so, res, fl, lat);
            n_checks += 3;
            if (res !== vt[i].res) begin n_fail++; $display("FAIL directed[%0d] out got %h want %h", i, res, vt[i].res); end
            if (fl !== vt[i].fl) begin n_fail++; $display("FAIL directed[%0d] flags got %b want %b", i, fl, vt[i].fl); end
            if (lat !== vt[i].lat) begin n_fail++; $display("FAIL directed[%0d] latency got %0d want %0d", i, lat, vt[i].lat); end
        end
    endtask

    task automatic test_random();
        logic [32:0] x;
        logic [2:0]  rm, fl, efl;
        logic        so;
        logic [31:0] res, eres;
        int          lat, elat;
        for (int i = 0; i < 300; i++) begin
            gen(x, rm, so);
            model(x, rm, so, eres, efl, elat);
            run_op(x, rm, so, res, fl, lat);
            n_checks += 3;
            if (res !== eres) begin n_fail++; $display("FAIL random[%0d] out x=%h rm=%0d so=%0d got %h want %h", i, x, rm, so, res, eres); end
            if (fl !== efl) begin n_fail++; $display("FAIL random[%0d] flags x=%h rm=%0d so=%0d got %b want %b", i, x, rm, so, fl, efl); end
            if (lat !== elat) begin n_fail++; $display("FAIL random[%0d] latency x=%h got %0d want %0d", i, x, lat, elat); end
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] x;
        logic [31:0] eres;
        logic [2:0]  efl;
        int          lat, elat;
        x = {1'b1, 9'h114, 23'h12_345};
        model(x, 3'd0, 1'b1, eres, efl, elat);
        send(x, 3'd0, 1'b1);
        wait_valid(lat);
        n_checks++;
        if (lat !== elat) begin n_fail++; $display("FAIL backpressure latency got %0d want %0d", lat, elat); end
        for (int i = 0; i < 5; i++) begin
            n_checks += 4;
            if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL backpressure[%0d] out_valid got %b want 1", i, bus.out_valid); end
            if (bus.out_bits_out !== eres) begin n_fail++; $display("FAIL backpressure[%0d] out got %h want %h", i, bus.out_bits_out, eres); end
            if (bus.out_bits_exception_flags !== efl) begin n_fail++; $display("FAIL backpressure[%0d] flags got %b want %b", i, bus.out_bits_exception_flags, efl); end
            if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL backpressure[%0d] in_ready got %b want 0", i, bus.in_ready); end
            @(posedge clk); #1;
        end
        ack();
        n_checks += 2;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL backpressure_release out_valid got %b want 0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL backpressure_release in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_reset_midshift();
        logic [31:0] res, eres;
        logic [2:0]  fl, efl;
        int          lat, elat;
        bit          seen;
        send(33'h0_8F80_0000, 3'd0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_checks += 2;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midshift_reset out_valid got %b want 0", bus.out_valid); end
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL midshift_reset in_ready got %b want 0", bus.in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midshift_release in_ready got %b want 1", bus.in_ready); end
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL midshift_discard out_valid got 1 want 0"); end
        model(33'h1_80A0_0000, 3'd2, 1'b1, eres, efl, elat);
        run_op(33'h1_80A0_0000, 3'd2, 1'b1, res, fl, lat);
        n_checks += 3;
        if (res !== eres) begin n_fail++; $display("FAIL midshift_next out got %h want %h", res, eres); end
        if (fl !== efl) begin n_fail++; $display("FAIL midshift_next flags got %b want %b", fl, efl); end
        if (lat !== elat) begin n_fail++; $display("FAIL midshift_next latency got %0d want %0d", lat, elat); end
    endtask

    task automatic test_back_to_back();
        logic [32:0] x;
        logic [2:0]  rm, efl;
        logic        so;
        logic [31:0] eres;
        int          lat, elat, prev_elat, prev_acc, n;
        prev_elat     = 0;
        prev_acc      = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            x  = {1'($urandom), 9'(256 + (i * 5) % 32), 23'($urandom)};
            rm = 3'($urandom_range(0, 7));
            so = 1'($urandom_range(0, 1));
            model(x, rm, so, eres, efl, elat);
            bus.in_bits_in            = x;
            bus.in_bits_rounding_mode = rm;
            bus.in_bits_signed_out    = so;
            bus.in_valid              = 1'b1;
            n = 0;
            while (!bus.in_ready && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            if (i > 0) begin
                n_checks++;
                if (cyc - prev_acc !== prev_elat + 1) begin
                    n_fail++;
                    $display("FAIL back_to_back[%0d] issue interval got %0d want %0d", i, cyc - prev_acc, prev_elat + 1);
                end
            end
            prev_acc  = cyc;
            prev_elat = elat;
            wait_valid(lat);
            n_checks += 2;
            if (bus.out_bits_out !== eres) begin n_fail++; $display("FAIL back_to_back[%0d] out got %h want %h", i, bus.out_bits_out, eres); end
            if (lat !== elat) begin n_fail++; $display("FAIL back_to_back[%0d] latency got %0d want %0d", i, lat, elat); end
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid              = 1'b0;
        bus.in_bits_in            = '0;
        bus.in_bits_rounding_mode = '0;
        bus.in_bits_signed_out    = 1'b0;
        bus.out_ready             = 1'b0;
        rst                       = 1'b1;
        #1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midshift();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
